// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [19:0]      op_onehot;
   logic             mem_ready;
   logic             fpu_done;
   logic             branch_taken;
   logic [2:0]       state;
   logic             mem_rd;
   logic             mem_wr;
   logic             iord;
   logic             ir_we;
   logic             pc_we;
   logic             alu_go;
   logic             fpu_go;
   logic             dest_sel;
   logic             rf_we;
   logic             illegal_op;
   logic             mem_fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  start, op_onehot, mem_ready, fpu_done, branch_taken,
      output state, mem_rd, mem_wr, iord, ir_we, pc_we, alu_go, fpu_go,
             dest_sel, rf_we, illegal_op, mem_fault, instr_count
   );

   modport slave (
      output start, op_onehot, mem_ready, fpu_done, branch_taken,
      input  state, mem_rd, mem_wr, iord, ir_we, pc_we, alu_go, fpu_go,
             dest_sel, rf_we, illegal_op, mem_fault, instr_count
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/FPWAIT/WB and drives the datapath strobes.
module multicycle_ctrl_fsm #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic                clk,
   input logic                reset,
   multicycle_ctrl_if.master  bus
);

   localparam int unsigned WaitW     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);
   // Last wait-counter value at which a missing mem_ready becomes a fault.
   localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StFpWait = 3'd5,
      StWb     = 3'd6,
      StHalt   = 3'd7
   } state_e;

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dest_q, dest_d;
   logic             illegal_q, illegal_d;
   logic             fault_q, fault_d;
   logic             fp_first_q, fp_first_d;
   logic             is_load_q, is_load_d;
   logic             is_store_q, is_store_d;
   logic             is_branch_q, is_branch_d;
   logic             is_jump_q, is_jump_d;
   logic             is_halt_q, is_halt_d;

   logic mem_rd, mem_wr, iord, ir_we, pc_we, alu_go, fpu_go, rf_we;
   logic one_hot, timeout_hit;

   assign one_hot     = ($countones(bus.op_onehot) == 1);
   // mem_ready on the limit cycle wins over the timeout.
   assign timeout_hit = TimeoutEn && (wait_q == WaitLast) && !bus.mem_ready;

   // State, class latches, flags and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         count_q     <= '0;
         dest_q      <= 1'b0;
         illegal_q   <= 1'b0;
         fault_q     <= 1'b0;
         fp_first_q  <= 1'b0;
         is_load_q   <= 1'b0;
         is_store_q  <= 1'b0;
         is_branch_q <= 1'b0;
         is_jump_q   <= 1'b0;
         is_halt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         count_q     <= count_d;
         dest_q      <= dest_d;
         illegal_q   <= illegal_d;
         fault_q     <= fault_d;
         fp_first_q  <= fp_first_d;
         is_load_q   <= is_load_d;
         is_store_q  <= is_store_d;
         is_branch_q <= is_branch_d;
         is_jump_q   <= is_jump_d;
         is_halt_q   <= is_halt_d;
      end
   end

   // Next-state logic and Moore strobes.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      count_d     = count_q;
      dest_d      = dest_q;
      illegal_d   = illegal_q;
      fault_d     = fault_q;
      fp_first_d  = 1'b0;
      is_load_d   = is_load_q;
      is_store_d  = is_store_q;
      is_branch_d = is_branch_q;
      is_jump_d   = is_jump_q;
      is_halt_d   = is_halt_q;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      alu_go      = 1'b0;
      fpu_go      = 1'b0;
      rf_we       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = StFetch;
         end
         StFetch: begin
            mem_rd = 1'b1;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end else if (timeout_hit) begin
               fault_d = 1'b1;
               state_d = StHalt;
            end
         end
         StDecode: begin
            if (!one_hot) begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end else begin
               is_load_d   = bus.op_onehot[2];
               is_store_d  = bus.op_onehot[3];
               is_branch_d = bus.op_onehot[14] | bus.op_onehot[15];
               is_jump_d   = bus.op_onehot[16];
               is_halt_d   = bus.op_onehot[17];
               // RS2-destination ops: LOAD, STORE, immediate class (bits 7-13).
               if (|{bus.op_onehot[13:7], bus.op_onehot[3:2]}) begin
                  dest_d = 1'b1;
               end else if (|{bus.op_onehot[19:18], bus.op_onehot[6:4], bus.op_onehot[1:0]}) begin
                  dest_d = 1'b0;
               end
               if (bus.op_onehot[18] | bus.op_onehot[19]) begin
                  fp_first_d = 1'b1;
                  state_d    = StFpWait;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            alu_go = 1'b1;
            if (is_load_q || is_store_q) begin
               state_d = StMem;
            end else if (is_jump_q || (is_branch_q && bus.branch_taken)) begin
               pc_we   = 1'b1;
               count_d = count_q + CNT_W'(1);
               state_d = StFetch;
            end else if (is_branch_q) begin
               count_d = count_q + CNT_W'(1);
               state_d = StFetch;
            end else if (is_halt_q) begin
               count_d = count_q + CNT_W'(1);
               state_d = StHalt;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            iord   = 1'b1;
            mem_rd = is_load_q;
            mem_wr = is_store_q;
            if (bus.mem_ready) begin
               if (is_load_q) begin
                  state_d = StWb;
               end else begin
                  count_d = count_q + CNT_W'(1);
                  state_d = StFetch;
               end
            end else if (timeout_hit) begin
               fault_d = 1'b1;
               state_d = StHalt;
            end
         end
         StFpWait: begin
            fpu_go = fp_first_q;
            if (bus.fpu_done) state_d = StWb;
         end
         StWb: begin
            rf_we   = 1'b1;
            count_d = count_q + CNT_W'(1);
            state_d = StFetch;
         end
         StHalt: begin
         end
         default: state_d = StIdle;
      endcase

      // Wait counter restarts on every state change, counts while waiting on memory.
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (state_q inside {StFetch, StMem}) begin
         wait_d = wait_q + WaitW'(1);
      end
   end

   assign bus.state       = state_q;
   assign bus.mem_rd      = mem_rd;
   assign bus.mem_wr      = mem_wr;
   assign bus.iord        = iord;
   assign bus.ir_we       = ir_we;
   assign bus.pc_we       = pc_we;
   assign bus.alu_go      = alu_go;
   assign bus.fpu_go      = fpu_go;
   assign bus.rf_we       = rf_we;
   assign bus.dest_sel    = dest_q;
   assign bus.illegal_op  = illegal_q;
   assign bus.mem_fault   = fault_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a small datapath responder plus a
// retire scoreboard (expected count/writeback pushed at issue, popped on retire).
module tb_multicycle_ctrl_fsm;

   localparam int unsigned CntW = 16;
   localparam int unsigned Tmo  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CntW)) bus ();

   multicycle_ctrl_fsm #(
      .CNT_W       (CntW),
      .MEM_TIMEOUT (Tmo)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [CntW-1:0] count;
      logic            wb;
      logic            dest;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Datapath responder configuration; a latency of -1 means never respond.
   logic [19:0] cur_op = '0;
   int          fetch_lat = 0;
   int          mem_lat = 0;
   int          fpu_lat = 0;
   logic        taken = 1'b0;
   int          hold = 0;
   logic [2:0]  prev_st = 3'd0;

   // Scoreboard / statistics state.
   logic [CntW-1:0] prev_cnt = '0;
   logic [CntW-1:0] exp_count = '0;
   logic            exp_dest_m = 1'b0;
   logic            wb_seen = 1'b0;
   logic            wb_dest = 1'b0;
   int st_cyc[8];
   int n_alu, n_fpu, n_rf, n_ir, n_pcx, n_memrd, n_memwr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_dest(input logic [19:0] op, input logic prev);
      if ((op & 20'h03F8C) != 0) return 1'b1;
      if ((op & 20'hC0073) != 0) return 1'b0;
      return prev;
   endfunction

   task automatic drive();
      int lat;
      lat = (bus.state == 3'd1) ? fetch_lat : mem_lat;
      bus.op_onehot    = cur_op;
      bus.branch_taken = taken;
      bus.mem_ready    = (bus.mem_rd || bus.mem_wr) && (lat >= 0) && (hold == lat);
      // fpu_done is also raised during FETCH, where it must be ignored.
      bus.fpu_done     = ((bus.state == 3'd5) && (hold == fpu_lat)) || (bus.state == 3'd1);
   endtask

   // One clock: track time-in-state, respond, then land on the falling edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (bus.state != prev_st) hold = 0;
      else hold++;
      prev_st = bus.state;
      drive();
      @(negedge clk);
   endtask

   task automatic sample();
      exp_t e;
      if (bus.rf_we) begin
         wb_seen = 1'b1;
         wb_dest = bus.dest_sel;
      end
      if (bus.instr_count != prev_cnt) begin
         check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_count", 32'(bus.instr_count), 32'(e.count));
            check_eq("sb_wb", 32'(wb_seen), 32'(e.wb));
            if (e.wb) check_eq("sb_dest", 32'(wb_dest), 32'(e.dest));
         end
         wb_seen  = 1'b0;
         prev_cnt = bus.instr_count;
      end
   endtask

   task automatic accumulate();
      st_cyc[bus.state]++;
      if (bus.alu_go) n_alu++;
      if (bus.fpu_go) n_fpu++;
      if (bus.rf_we) n_rf++;
      if (bus.ir_we) n_ir++;
      if (bus.pc_we && bus.state == 3'd3) n_pcx++;
      if (bus.iord && bus.mem_rd) n_memrd++;
      if (bus.iord && bus.mem_wr) n_memwr++;
   endtask

   // Run until the next FETCH or HALT after leaving FETCH, bounded.
   task automatic run_loop(output bit done);
      bit left;
      foreach (st_cyc[k]) st_cyc[k] = 0;
      n_alu = 0; n_fpu = 0; n_rf = 0; n_ir = 0; n_pcx = 0; n_memrd = 0; n_memwr = 0;
      left = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         sample();
         if (bus.state != 3'd1) left = 1'b1;
         if (left && (bus.state == 3'd1 || bus.state == 3'd7)) begin
            done = 1'b1;
            break;
         end
         accumulate();
         cycle();
      end
   endtask

   task automatic run_instr(input string name, input logic [19:0] op, input int flat,
                            input int mlat, input int fplat, input logic tk);
      bit   done;
      logic ld, st, fp, jmp, br, wb;
      cur_op = op; fetch_lat = flat; mem_lat = mlat; fpu_lat = fplat; taken = tk;
      drive();
      #1;
      ld  = op[2];
      st  = op[3];
      fp  = op[18] | op[19];
      jmp = op[16];
      br  = op[14] | op[15];
      wb  = ((op & 20'h3C008) == 0);
      exp_dest_m = exp_dest(op, exp_dest_m);
      exp_count  = exp_count + 1'b1;
      sb_q.push_back('{count: exp_count, wb: wb, dest: exp_dest_m});
      run_loop(done);
      check_eq({name, ".done"}, 32'(done), 32'd1);
      check_eq({name, ".fetch_cyc"}, st_cyc[1], flat + 1);
      check_eq({name, ".decode_cyc"}, st_cyc[2], 1);
      check_eq({name, ".ir_we"}, n_ir, 1);
      check_eq({name, ".alu_go"}, n_alu, fp ? 0 : 1);
      check_eq({name, ".fpu_go"}, n_fpu, fp ? 1 : 0);
      check_eq({name, ".fpwait_cyc"}, st_cyc[5], fp ? fplat + 1 : 0);
      check_eq({name, ".rf_we"}, n_rf, wb ? 1 : 0);
      check_eq({name, ".pc_we_exec"}, n_pcx, (jmp || (br && tk)) ? 1 : 0);
      check_eq({name, ".mem_rd_cyc"}, n_memrd, ld ? mlat + 1 : 0);
      check_eq({name, ".mem_wr_cyc"}, n_memwr, st ? mlat + 1 : 0);
      check_eq({name, ".dest_sel"}, 32'(bus.dest_sel), 32'(exp_dest_m));
      check_eq({name, ".mem_fault"}, 32'(bus.mem_fault), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      prev_st = bus.state; hold = 0;
      prev_cnt = '0; exp_count = '0; exp_dest_m = 1'b0; wb_seen = 1'b0;
   endtask

   task automatic start_seq();
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask

   function automatic logic [7:0] strobes();
      return {bus.mem_rd, bus.mem_wr, bus.iord, bus.ir_we, bus.pc_we,
              bus.alu_go, bus.fpu_go, bus.rf_we};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      bit done;
      bus.start = 1'b0; bus.op_onehot = '0; bus.mem_ready = 1'b0;
      bus.fpu_done = 1'b0; bus.branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.state", 32'(bus.state), 32'd0);
      check_eq("rst.strobes", 32'(strobes()), 32'd0);
      check_eq("rst.dest_sel", 32'(bus.dest_sel), 32'd0);
      check_eq("rst.flags", 32'({bus.illegal_op, bus.mem_fault}), 32'd0);
      check_eq("rst.count", 32'(bus.instr_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      prev_st = bus.state;

      // Instruction stream.
      start_seq();
      run_instr("add",    20'h00001, 1,  0, 0, 1'b0);
      run_instr("load",   20'h00004, 0,  3, 0, 1'b0);
      run_instr("mulf",   20'h80000, 0,  0, 4, 1'b0);
      run_instr("beqz_t", 20'h04000, 0,  0, 0, 1'b1);
      run_instr("beqz_n", 20'h04000, 0,  0, 0, 1'b0);
      run_instr("store",  20'h00008, 2,  1, 0, 1'b0);
      run_instr("bnez_t", 20'h08000, 0,  0, 0, 1'b1);
      run_instr("j",      20'h10000, 0,  0, 0, 1'b0);
      run_instr("sge",    20'h00010, 0,  0, 0, 1'b0);
      run_instr("addi",   20'h00200, 3,  0, 0, 1'b0);
      run_instr("halt",   20'h20000, 0,  0, 0, 1'b0);
      check_eq("halt.state", 32'(bus.state), 32'd7);
      bus.start = 1'b1;
      repeat (3) cycle();
      check_eq("halt.stays", 32'(bus.state), 32'd7);
      check_eq("halt.strobes", 32'(strobes()), 32'd0);
      check_eq("halt.count", 32'(bus.instr_count), 32'(exp_count));

      // Two-hot opcode.
      do_reset();
      cur_op = 20'h00003; fetch_lat = 0;
      start_seq();
      drive();
      run_loop(done);
      check_eq("illegal.done", 32'(done), 32'd1);
      check_eq("illegal.flag", 32'(bus.illegal_op), 32'd1);
      check_eq("illegal.state", 32'(bus.state), 32'd7);
      bus.start = 1'b1;
      repeat (3) cycle();
      check_eq("illegal.stays", 32'(bus.state), 32'd7);
      check_eq("illegal.strobes", 32'(strobes()), 32'd0);
      check_eq("illegal.count", 32'(bus.instr_count), 32'd0);

      // Fetch never answered.
      do_reset();
      cur_op = 20'h00001; fetch_lat = -1;
      start_seq();
      drive();
      run_loop(done);
      check_eq("tmo.done", 32'(done), 32'd1);
      check_eq("tmo.fetch_cyc", st_cyc[1], Tmo);
      check_eq("tmo.fault", 32'(bus.mem_fault), 32'd1);
      check_eq("tmo.illegal", 32'(bus.illegal_op), 32'd0);
      check_eq("tmo.state", 32'(bus.state), 32'd7);
      check_eq("tmo.strobes", 32'(strobes()), 32'd0);

      // Reset while a LOAD waits in MEM.
      do_reset();
      cur_op = 20'h00001; fetch_lat = 0;
      start_seq();
      run_instr("add2", 20'h00001, 0, 0, 0, 1'b0);
      cur_op = 20'h00004; mem_lat = -1;
      drive();
      for (int i = 0; i < 10 && bus.state != 3'd4; i++) cycle();
      cycle();
      check_eq("rstmem.in_mem", 32'(bus.state), 32'd4);
      check_eq("rstmem.mem_rd", 32'({bus.mem_rd, bus.iord}), 32'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rstmem.state", 32'(bus.state), 32'd0);
      check_eq("rstmem.strobes", 32'(strobes()), 32'd0);
      check_eq("rstmem.count", 32'(bus.instr_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      check_eq("sb.empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
